data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised data memory for the MEM stage of the pipeline. Single-port word array with
//  byte-enable writes, a valid/ready request side, configurable wait states and a one-cycle
//  response pulse with error flag. Replaces the fixed 10-word, zero-latency data memory.
//  The pipeline hazard logic stalls on 'busy'.
// PARAMETERS
//  DATA_W      32  word width in bits, multiple of 8; BYTES = DATA_W/8
//  DEPTH       16  number of words, >= 2
//  ADDR_W      32  byte-address width
//  WAIT_CYCLES  1  extra cycles between accept and commit/read, 0..15
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept; high only in IDLE
//  req_write  in   1         1 = store, 0 = load
//  req_addr   in   ADDR_W    byte address
//  req_wdata  in   DATA_W    store data
//  req_be     in   BYTES     store byte enables; bit i -> bits [8i+7:8i]
//  rsp_valid  out  1         one-cycle response pulse
//  rsp_rdata  out  DATA_W    load data; 0 for stores and errors
//  rsp_err    out  1         misaligned or out-of-range; valid with rsp_valid
//  busy       out  1         request in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    busy=0, wait counter=0. Array contents are NOT reset; simulation initialises them to 0.
//  - Accept: req_valid & req_ready at a clk edge. Latch write, addr, wdata and be.
//  - FSM:
//    IDLE -> WAIT on accept when WAIT_CYCLES>0, counter loaded with WAIT_CYCLES-1.
//    IDLE -> RESP on accept when WAIT_CYCLES==0.
//    WAIT: decrement counter; go to RESP when the counter reaches 0.
//    RESP: rsp_valid=1 for exactly one cycle, then IDLE.
//  - Latency: the accept edge is followed by WAIT_CYCLES cycles in WAIT, then the RESP cycle.
//    rsp_valid rises WAIT_CYCLES+1 cycles after accept.
//  - Throughput: one request per WAIT_CYCLES+2 cycles. req_ready=0 in WAIT and RESP.
//  - Address decode: word index = addr >> log2(BYTES).
//    misaligned   = addr[log2(BYTES)-1:0] != 0.
//    out_of_range = word index >= DEPTH; index bits above log2(DEPTH) count toward range.
//    err = misaligned | out_of_range.
//  - Store commit: on the edge entering RESP, only when err=0. Writes the lanes where be=1;
//    other lanes are kept. be=0 with err=0 is a legal no-op store (rsp_err=0).
//  - Load: rsp_rdata = mem[index], registered on the edge entering RESP. 0 when err=1.
//  - Errors never modify the array. rsp_err=1 coincides with rsp_valid only.
//  - rsp_rdata and rsp_err hold their last values after RESP. Only rsp_valid qualifies them.
//  - Inputs are ignored while req_ready=0; the latched request is not affected.
//  - Reset mid-operation: an uncommitted store is dropped, no response is issued, IDLE next.
// STRUCTURE
//  - Package mem_pkg: state enum {IDLE, WAIT, RESP}; localparams BYTES, OFF_W=$clog2(BYTES),
//    IDX_W=$clog2(DEPTH).
//  - Sub-module mem_array_be: DEPTH x DATA_W storage, synchronous byte-enable write,
//    synchronous read. The controller FSM, counter and decode live in data_memory_ctrl.
// TESTING (DATA_W=32, DEPTH=16, WAIT_CYCLES=1 unless noted)
//  1 Store addr=0x8, wdata=0xDEADBEEF, be=4'hF. Then load 0x8
//    -> rsp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
//  2 From 1: store be=4'b0010, wdata=0x0000_5500. Then load 0x8
//    -> rdata=0xDEAD55EF.
//  3 Load addr=0x6 (misaligned) and store addr=0x40 (index 16)
//    -> err=1, rdata=0, mem[0] and mem[15] unchanged.
//  4 WAIT_CYCLES=0, back-to-back requests with req_valid held high
//    -> accept every 2nd cycle, rsp_valid 1 cycle after each accept.
//  5 Store to 0x4 accepted, rst_n pulsed low during WAIT
//    -> no rsp_valid, req_ready=1 after release, load 0x4 returns the old value.
//  6 WAIT_CYCLES=3, busy and req_ready sampled every cycle
//    -> busy high for 4 cycles after accept, req_ready low for the same 4 cycles.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and default geometry for the MEM-stage data memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int BYTES      = DEF_DATA_W / 8;
  localparam int OFF_W      = $clog2(BYTES);
  localparam int IDX_W      = $clog2(DEF_DEPTH);

endpackage

// File: rtl/data_memory_ctrl_array.sv
// DEPTH x DATA_W word storage with byte-lane writes and a registered read port.
module mem_array_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // storage is intentionally left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: valid/ready request side, programmable wait states,
// one-cycle response pulse carrying load data and an address error flag.
//
// state | meaning
// IDLE  | ready for a new request
// WAIT  | request latched, burning wait cycles
// RESP  | rsp_valid pulse; store committed / load data registered on entry
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int LANES     = DATA_W / 8;
  localparam int OFF_SHIFT = $clog2(LANES);
  localparam int IDX_BITS  = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LANES - 1);

  state_t state, state_nxt;
  logic [3:0] cnt;

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [LANES-1:0]  lat_be;

  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [LANES-1:0]  cur_be;
  logic [ADDR_W-1:0] word_full;

  logic accept, go_resp, misaligned, out_of_range, err;
  logic wr_en, rd_en, rdata_sel;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = req_valid && (state == IDLE);

  // with zero wait states the commit happens on the accept edge, before the latch is loaded
  assign cur_write = (state == IDLE) ? req_write : lat_write;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign cur_be    = (state == IDLE) ? req_be    : lat_be;

  assign word_full    = cur_addr >> OFF_SHIFT;
  assign misaligned   = (cur_addr & OFF_MASK) != '0;
  assign out_of_range = word_full >= ADDR_W'(DEPTH);
  assign err          = misaligned || out_of_range;

  assign go_resp = (state_nxt == RESP);
  assign wr_en   = go_resp && cur_write && !err;
  assign rd_en   = go_resp && !cur_write && !err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= WAIT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err   <= 1'b0;
      rdata_sel <= 1'b0;
    end else if (go_resp) begin
      rsp_err   <= err;
      rdata_sel <= !cur_write && !err;
    end
  end

  mem_array_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_BITS)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .idx   (word_full[IDX_BITS-1:0]),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (arr_rdata)
  );

  assign rsp_rdata = rdata_sel ? arr_rdata : '0;
  assign rsp_valid = (state == RESP);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule
